data_mem_mmio: RTL and testbench
================================

Name: data_mem_mmio

Overview:
- Responder (memory-side) end of the pipelined core's data-memory interface.
- Receives the core's M-stage signals (memwrite, address, write data) and returns read data in the same cycle.
- Contains word RAM plus a small MMIO block: console byte FIFO with valid/ready drain, free-running cycle counter, and sticky test-done register.
- Sits beside the core at top level; serves as the simulation/FPGA data memory.

Parameters:
- WIDTH, 32, data/address width (MMIO map below is defined for 32).
- DEPTH, 64, RAM size in words. Power of 2, at least 2.
- FIFO_DEPTH, 8, console FIFO entries. Power of 2, at least 2.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- memwrite  in  WIDTH? no: 1  store strobe from core M stage.
- addr  in  WIDTH  byte address from core (aluresult).
- writedata  in  WIDTH  store data from core.
- readdata  out  WIDTH  load data to core, combinational from addr.
- tx_valid  out  1  console FIFO non-empty.
- tx_data  out  8  FIFO head byte; valid only when tx_valid=1.
- tx_ready  in  1  consumer accepts the head byte.
- done  out  1  sticky; set by a TOHOST write.
- done_code  out  WIDTH  value of the TOHOST write.
- err  out  1  sticky; set by a bad write.
- overflow  out  1  sticky; set when a console byte is dropped.

Behaviour:
- One clock domain.
- Reset values: tx_valid=0, done=0, done_code=0, err=0, overflow=0, cycle counter=0, FIFO empty.
- RAM contents are not reset.

Address map (all word-aligned):
- RAM region: addr < DEPTH*4. Word index is addr[log2(DEPTH)+1:2].
- CONSOLE 0xFFFFFF00:
  - Write pushes writedata[7:0] into the FIFO.
  - Read returns {30'b0, full, empty}.
- CYCLE 0xFFFFFF04:
  - Read returns the counter.
  - Write loads the counter with writedata.
- TOHOST 0xFFFFFF08:
  - Write sets done=1 and done_code=writedata.
  - Read returns done_code.
- Any other address: read returns 0, write is ignored and sets err.
- Misaligned write (addr[1:0]!=0): ignored, sets err.
- Misaligned read: returns the word at addr with bits [1:0] ignored.

Reads and writes:
- Reads are purely combinational, zero latency; there is no read strobe.
- Writes commit on the rising edge when memwrite=1.
- Read-during-write to the same location shows the old value; the new value is visible the next cycle.

Cycle counter:
- Increments by 1 each cycle; wraps 0xFFFFFFFF -> 0.
- A CYCLE write takes precedence over the increment that cycle.
- Freezes (holds) while done=1.

TOHOST:
- A second TOHOST write overwrites done_code; done stays 1.
- Only reset clears done and done_code.

Console FIFO:
- Pop occurs when tx_valid && tx_ready; tx_data shows the next entry on the following cycle.
- Push when not full: byte accepted.
- Push when full:
  - With a pop in the same cycle: push accepted, count unchanged.
  - Otherwise: byte dropped, overflow set.
- Push into an empty FIFO: tx_valid rises on the next cycle (no fall-through).
- Simultaneous push and pop when count≥1: count unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH. Use an extra pointer bit or a count to distinguish full from empty.

Reset:
- Asserting rst mid-operation immediately clears all state listed above.
- In-flight FIFO contents are lost.
- RAM keeps its contents.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10 and load 0x10 in the same cycle -> readdata shows the old value; next cycle readdata=0xDEADBEEF.
- Write CYCLE=100 at cycle t -> read at t+1 = 100, at t+5 = 104; then TOHOST write 0x1 -> done=1, done_code=1, counter holds its value.
- tx_ready=0, push 9 bytes 0x41..0x49 with FIFO_DEPTH=8 -> byte 0x49 dropped, overflow=1, CONSOLE read=0x2 (full). Then tx_ready=1 -> drains 0x41..0x48 in order, final CONSOLE read=0x1 (empty).
- With the FIFO full, push 0x50 while popping -> push accepted, overflow stays 0, 0x50 emerges last.
- Write to 0x14 with addr[1:0]=2, and write to unmapped 0x8000 -> RAM unchanged, err=1; a read of 0x8000 returns 0.
- Assert rst asynchronously mid-drain with 3 bytes queued -> tx_valid=0, done=0, err=0 and counter=0 immediately; RAM word at 0x10 still reads 0xDEADBEEF.

Source files
------------

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: single-cycle data memory with console FIFO, cycle counter and test-done MMIO.
module data_mem_mmio #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int FIFO_DEPTH = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             done,
  output logic [WIDTH-1:0] done_code,
  output logic             err,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [WIDTH-1:0] CONSOLE = WIDTH'(32'hFFFFFF00);
  localparam logic [WIDTH-1:0] CYCLE = WIDTH'(32'hFFFFFF04);
  localparam logic [WIDTH-1:0] TOHOST = WIDTH'(32'hFFFFFF08);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [FW-1:0] rdPtr, wrPtr;
  logic [FW:0] count;
  logic [WIDTH-1:0] cycles, wordAddr;
  logic aligned, isRam, isCon, isCyc, isHost, wrOk, full, empty, push, pop, accept;
  assign wordAddr = {addr[WIDTH-1:2], 2'b00};
  assign aligned = addr[1:0] == 2'b00;
  assign isRam = wordAddr < WIDTH'(DEPTH * 4);
  assign isCon = wordAddr == CONSOLE;
  assign isCyc = wordAddr == CYCLE;
  assign isHost = wordAddr == TOHOST;
  assign wrOk = memwrite && aligned;
  assign full = count == (FW + 1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign pop = !empty && tx_ready;
  assign push = wrOk && isCon;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign accept = push && (!full || pop);
  assign tx_valid = !empty;
  assign tx_data = fifo[rdPtr];
  assign readdata = isRam ? mem[addr[AW+1:2]] :
                    isCon ? {{(WIDTH-2){1'b0}}, full, empty} :
                    isCyc ? cycles :
                    isHost ? done_code : '0;
  always_ff @(posedge clk) begin
    if (wrOk && isRam) mem[addr[AW+1:2]] <= writedata;
    if (accept) fifo[wrPtr] <= writedata[7:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      cycles <= '0;
      done <= 1'b0;
      done_code <= '0;
      err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) wrPtr <= wrPtr + FW'(1);
      if (pop) rdPtr <= rdPtr + FW'(1);
      count <= count + (FW + 1)'(accept) - (FW + 1)'(pop);
      cycles <= (wrOk && isCyc) ? writedata : done ? cycles : cycles + WIDTH'(1);
      if (wrOk && isHost) begin
        done <= 1'b1;
        done_code <= writedata;
      end
      if (memwrite && (!aligned || !(isRam || isCon || isCyc || isHost))) err <= 1'b1;
      if (push && !accept) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed bench with a byte scoreboard for the console FIFO.
module tb_data_mem_mmio;
  localparam logic [31:0] CONSOLE = 32'hFFFFFF00;
  localparam logic [31:0] CYCLE = 32'hFFFFFF04;
  localparam logic [31:0] TOHOST = 32'hFFFFFF08;
  logic clk = 0, rst = 1, memwrite = 0, tx_ready = 0;
  logic [31:0] addr = 0, writedata = 0, readdata, done_code;
  logic tx_valid, done, err, overflow;
  logic [7:0] tx_data;
  int nChecks = 0, nErr = 0;
  logic [7:0] q[$];
  data_mem_mmio dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .addr(addr), .writedata(writedata),
    .readdata(readdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .done(done), .done_code(done_code), .err(err), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    if (tx_valid && tx_ready) begin
      if (q.size() == 0) chk("unexpectedPop", 32'(tx_data), 32'hFFFFFFFF);
      else chk("txData", 32'(tx_data), 32'(q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1;
    cycle();
    memwrite = 0;
  endtask
  task automatic pushByte(input logic [7:0] b, input logic rdy);
    tx_ready = rdy;
    if (q.size() < 8 || (rdy && q.size() > 0)) q.push_back(b);
    wr(CONSOLE, {24'h0, b});
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, readdata, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) cycle();
    chk("rstTxValid", 32'(tx_valid), 0);
    chk("rstDone", 32'(done), 0);
    chk("rstDoneCode", done_code, 0);
    chk("rstErr", 32'(err), 0);
    chk("rstOverflow", 32'(overflow), 0);
    rd("rstCycle", CYCLE, 0);
    rd("rstConsole", CONSOLE, 32'h1);
    rst = 0;
    // read-during-write shows the old word
    wr(32'h10, 32'h11111111);
    wr(32'h14, 32'h22222222);
    addr = 32'h10;
    writedata = 32'hDEADBEEF;
    memwrite = 1;
    #1;
    chk("rdDuringWr", readdata, 32'h11111111);
    cycle();
    memwrite = 0;
    #1;
    chk("rdAfterWr", readdata, 32'hDEADBEEF);
    rd("misalignedRd", 32'h13, 32'hDEADBEEF);
    wr(CYCLE, 100);
    rd("cycleLoad", CYCLE, 100);
    repeat (4) cycle();
    rd("cyclePlus4", CYCLE, 104);
    wr(TOHOST, 1);
    chk("done", 32'(done), 1);
    chk("doneCode", done_code, 1);
    rd("cycleAtDone", CYCLE, 105);
    repeat (3) cycle();
    rd("cycleFrozen", CYCLE, 105);
    wr(TOHOST, 7);
    chk("doneStays", 32'(done), 1);
    rd("doneCode2", TOHOST, 7);
    // console: empty push has no fall-through
    tx_ready = 0;
    addr = CONSOLE;
    writedata = 32'h41;
    memwrite = 1;
    #1;
    chk("noFallThrough", 32'(tx_valid), 0);
    q.push_back(8'h41);
    cycle();
    memwrite = 0;
    chk("txValidRise", 32'(tx_valid), 1);
    for (int i = 1; i < 8; i++) pushByte(8'(8'h41 + i), 0);
    chk("fullNoOvf", 32'(overflow), 0);
    rd("consoleFull", CONSOLE, 32'h2);
    chk("headByte", 32'(tx_data), 32'h41);
    pushByte(8'h50, 1);
    chk("pushPopOvf", 32'(overflow), 0);
    rd("stillFull", CONSOLE, 32'h2);
    pushByte(8'h49, 0);
    chk("overflow", 32'(overflow), 1);
    tx_ready = 1;
    for (int i = 0; i < 20 && tx_valid; i++) cycle();
    chk("drainCount", 32'(q.size()), 0);
    chk("drainedValid", 32'(tx_valid), 0);
    rd("consoleEmpty", CONSOLE, 32'h1);
    // bad writes leave RAM untouched
    chk("errClear", 32'(err), 0);
    wr(32'h16, 32'hBADBAD00);
    chk("errMisaligned", 32'(err), 1);
    rd("ramKept", 32'h14, 32'h22222222);
    wr(32'h8000, 32'h12345678);
    rd("unmappedRd", 32'h8000, 0);
    chk("errUnmapped", 32'(err), 1);
    // async reset mid-drain
    for (int i = 0; i < 3; i++) pushByte(8'(8'h60 + i), 0);
    tx_ready = 1;
    cycle();
    #2;
    rst = 1;
    q.delete();
    addr = CYCLE;
    #1;
    chk("asyncTxValid", 32'(tx_valid), 0);
    chk("asyncDone", 32'(done), 0);
    chk("asyncDoneCode", done_code, 0);
    chk("asyncErr", 32'(err), 0);
    chk("asyncOverflow", 32'(overflow), 0);
    chk("asyncCycle", readdata, 0);
    rd("ramSurvives", 32'h10, 32'hDEADBEEF);
    cycle();
    rst = 0;
    rd("cycleZero", CYCLE, 0);
    cycle();
    rd("cycleOne", CYCLE, 1);
    chk("postRstValid", 32'(tx_valid), 0);
    wr(CYCLE, 32'hFFFFFFFF);
    rd("cycleMax", CYCLE, 32'hFFFFFFFF);
    cycle();
    rd("cycleWrap", CYCLE, 0);
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end
endmodule
